// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants and types for the 7-segment scan controller
// and its clock prescaler.
package seven_seg_scan_ctrl_pkg;

    localparam int IDX_W           = 2;
    localparam int DEFAULT_CLK_DIV = 50000;
    localparam int DIGIT_COUNT     = 4;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef logic [IDX_W-1:0] digit_idx_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
    } frame_data_t;

    // Active-low one-hot anode pattern for the given digit position.
    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-side bundle: value/dp loading and blanking control in,
// the decoder feed and anode enables out.
interface seven_seg_scan_ctrl_if;

    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  Hex;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    modport master (
        output value_in, dp_in, load, blank_lz,
        input  Hex, dp, an, frame_tick
    );

    modport slave (
        input  value_in, dp_in, load, blank_lz,
        output Hex, dp, an, frame_tick
    );

endinterface

// File: rtl/seven_seg_scan_ctrl_clk_prescaler.sv
// Free-running divider that pulses tick for one cycle every CLK_DIV clocks.
// Shared with other display and debounce blocks.
module clk_prescaler
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Explicit wrap so non-power-of-two dividers work.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with frame-aligned
// double buffering and optional leading-zero blanking.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int NUM_DIGITS = DIGIT_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_ctrl_if.slave bus
);

    logic        slot_tick;
    logic        wrap_tick;
    digit_idx_t  index;
    frame_data_t active;
    frame_data_t pending;
    frame_data_t incoming;
    logic        pending_valid;
    logic [3:0]  blank_mask;
    logic        upper_zero;

    clk_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(slot_tick)
    );

    assign wrap_tick = slot_tick && (index == digit_idx_t'(NUM_DIGITS - 1));
    assign incoming  = {bus.value_in, bus.dp_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
        end else if (slot_tick) begin
            index <= index + 1'b1;
        end
    end

    // A load coinciding with the frame boundary bypasses the pending slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (bus.load) begin
                pending <= incoming;
            end
            if (wrap_tick) begin
                if (bus.load) begin
                    active <= incoming;
                end else if (pending_valid) begin
                    active <= pending;
                end
                pending_valid <= 1'b0;
            end else if (bus.load) begin
                pending_valid <= 1'b1;
            end
        end
    end

    // Scan downward from the top digit; a lit point stops the blanking too.
    always_comb begin
        blank_mask = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero && (active.value[4*i +: 4] == 4'h0) && !active.dp[i];
            blank_mask[i] = bus.blank_lz && upper_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Hex        <= 4'h0;
            bus.dp         <= 1'b0;
            bus.an         <= ANODE_OFF;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.frame_tick <= wrap_tick;
            if (blank_mask[index]) begin
                bus.Hex <= 4'h0;
                bus.dp  <= 1'b0;
                bus.an  <= ANODE_OFF;
            end else begin
                bus.Hex <= active.value[{index, 2'b00} +: 4];
                bus.dp  <= active.dp[index];
                bus.an  <= anode_for(index);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: directed scenarios followed by
// randomized traffic, checked against a cycle-position reference model.
module tb_seven_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] hex;
        logic       dp;
        logic       ft;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if bus();

    seven_seg_scan_ctrl #(
        .CLK_DIV   (DIV),
        .NUM_DIGITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    obs_t  expQ[$];
    string tagQ[$];
    int    errors = 0;
    int    checks = 0;
    string phase  = "reset";
    logic  curBlank = 1'b0;

    // Model: k counts clock edges since reset release; the displayed digit
    // and frame position follow directly from k.
    int          k = 0;
    logic [15:0] actV = '0;
    logic [3:0]  actDp = '0;
    logic [15:0] pendV = '0;
    logic [3:0]  pendDp = '0;
    bit          pendValid = 0;

    function automatic obs_t predict(input logic b);
        obs_t       o;
        int         d;
        int         msd;
        logic [3:0] oneHot;
        d   = (k / DIV) % 4;
        msd = 0;
        for (int j = 0; j < 4; j++) begin
            if (actV[4*j +: 4] != 4'h0 || actDp[j]) msd = j;
        end
        o.ft = ((k % FRAME) == FRAME - 1);
        if (b && d > msd) begin
            o.an  = 4'b1111;
            o.hex = 4'h0;
            o.dp  = 1'b0;
        end else begin
            oneHot = 4'b0001 << d;
            o.an   = ~oneHot;
            o.hex  = actV[4*d +: 4];
            o.dp   = actDp[d];
        end
        return o;
    endfunction

    task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] v,
                                 input logic [3:0] p, input logic b);
        obs_t e;
        rst          = r;
        bus.load     = ld;
        bus.value_in = v;
        bus.dp_in    = p;
        bus.blank_lz = b;
        if (r) begin
            e = '{an: 4'b1111, hex: 4'h0, dp: 1'b0, ft: 1'b0};
            k = 0;
            actV = '0;
            actDp = '0;
            pendValid = 0;
        end else begin
            e = predict(b);
            if ((k % FRAME) == FRAME - 1) begin
                if (ld) begin
                    actV  = v;
                    actDp = p;
                end else if (pendValid) begin
                    actV  = pendV;
                    actDp = pendDp;
                end
                pendValid = 0;
            end else if (ld) begin
                pendV     = v;
                pendDp    = p;
                pendValid = 1;
            end
            k++;
        end
        expQ.push_back(e);
        tagQ.push_back($sformatf("%s@k%0d", phase, k));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 16'($urandom), 4'($urandom), curBlank);
        end
    endtask

    task automatic fail_timeout(input string what);
        checks++;
        errors++;
        $display("[TB] FAIL timeout %s: position not reached, got k=%0d", what, k);
    endtask

    // Step until the next edge samples the given digit slot and sub-position.
    task automatic waitSlot(input int d, input int pos);
        int n;
        n = 0;
        while (!(((k / DIV) % 4) == d && (k % DIV) == pos) && n < 2 * FRAME) begin
            idle(1);
            n++;
        end
        if (n >= 2 * FRAME) fail_timeout($sformatf("slot%0d.%0d", d, pos));
    endtask

    task automatic checkOutput(input obs_t e, input string tag);
        obs_t a;
        a = {bus.an, bus.Hex, bus.dp, bus.frame_tick};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s: got an=%b Hex=%h dp=%b frame_tick=%b, expected an=%b Hex=%h dp=%b frame_tick=%b",
                     tag, a.an, a.hex, a.dp, a.ft, e.an, e.hex, e.dp, e.ft);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front(), tagQ.pop_front());
        end
    end

    initial begin
        logic        r;
        logic        ld;
        logic [15:0] v;
        logic [3:0]  p;
        int          n;

        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;

        phase = "reset";
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hBEEF, 4'hF, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

        phase = "scan";
        curBlank = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0100, curBlank);
        idle(3 * FRAME);

        phase = "buffer";
        waitSlot(0, 1);
        applyStimulus(1'b0, 1'b1, 16'hAAAA, 4'b0000, curBlank);
        idle(FRAME);
        waitSlot(1, 1);
        applyStimulus(1'b0, 1'b1, 16'h5555, 4'b0000, curBlank);
        idle(2 * FRAME);

        phase = "coincident";
        waitSlot(0, 1);
        applyStimulus(1'b0, 1'b1, 16'h1111, 4'b0001, curBlank);
        waitSlot(3, DIV - 1);
        applyStimulus(1'b0, 1'b1, 16'h0F0F, 4'b0000, curBlank);
        idle(2 * FRAME);

        phase = "blank";
        curBlank = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0007, 4'b0000, curBlank);
        idle(2 * FRAME);
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, curBlank);
        idle(2 * FRAME);
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0100, curBlank);
        idle(2 * FRAME);
        curBlank = 1'b0;
        idle(FRAME);

        phase = "midreset";
        waitSlot(1, 0);
        applyStimulus(1'b0, 1'b1, 16'h9876, 4'b1010, curBlank);
        waitSlot(2, 1);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, curBlank);
        idle(2 * FRAME);

        phase = "random";
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 7) == 0);
            v  = 16'($urandom);
            p  = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                v = v >> (4 * $urandom_range(0, 4));
                p = p >> $urandom_range(0, 4);
            end
            if ($urandom_range(0, 49) == 0) curBlank = ~curBlank;
            applyStimulus(r, ld, v, p, curBlank);
        end

        n = 0;
        while (expQ.size() > 0 && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expected outputs left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Sits directly upstream of the Hex-to-7-segment decoder: holds a 16-bit value and a decimal-point mask, and steps through the digits.
- Each slot presents one nibble on Hex plus its dp bit to the decoder, and drives the matching active-low anode enable.
- New values are double-buffered and only take effect at a frame boundary, so a displayed frame never mixes old and new digits.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot; legal range 2..2^20; simulation uses 4.
- NUM_DIGITS, 4, number of digits scanned; fixed at 4 in this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- value_in  input  16  value to display; digit i = value_in[4i+3:4i]; digit 0 is rightmost.
- dp_in  input  4  decimal-point mask; bit i = point of digit i.
- load  input  1  one-cycle strobe that captures value_in/dp_in into the pending buffer.
- blank_lz  input  1  1 = blank leading zeros.
- Hex  output  4  nibble to the decoder's Hex input, registered.
- dp  output  1  point bit to the decoder's dp input, registered.
- an  output  4  anode enables, active-low, one-hot-low; registered.
- frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0, registered.

Behaviour:
- Reset (rst high at a clk edge):
  - prescaler=0, digit index=0.
  - active value=0, active dp=0; pending buffer=0, pending flag=0.
  - Hex=4'h0, dp=0, an=4'b1111, frame_tick=0.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - slot_tick is asserted in the cycle where the count equals CLK_DIV-1.
- Digit index:
  - Advances on slot_tick in the order 0→1→2→3→0.
  - wrap_tick = slot_tick AND index==3.
- Load:
  - load=1 writes pending <= {value_in, dp_in} and sets the pending flag.
  - A second load before the frame boundary overwrites pending (last write wins).
- Frame boundary (wrap_tick):
  - If load=1 in the same cycle, active <= value_in/dp_in directly, and the pending flag is cleared.
  - Else, if the pending flag is set, active <= pending and the pending flag is cleared.
  - Else, active is unchanged.
  - frame_tick is 1 in the following cycle.
- Leading-zero blanking (blank_lz=1):
  - Digit i (i=1..3) is blanked when active nibbles i..3 are all zero AND active dp bits i..3 are all zero.
  - Digit 0 is never blanked, so a value of 0 shows as a single "0".
  - blank_lz is sampled live every cycle; it is not buffered.
- Output register, updated every cycle outside reset from the current index and active value:
  - Non-blanked digit: Hex=nibble[index], dp=dp_active[index], an = ~(4'b0001<<index).
  - Blanked digit: an=4'b1111, Hex=4'h0, dp=0.
- Latency:
  - Outputs lag an index change by 1 clk.
  - The first cycle after reset release shows an=4'b1110.
  - A load reaches the outputs no earlier than the first slot after the next wrap_tick.
- Reset mid-scan: on the next edge everything returns to its reset values and pending data is discarded. A load asserted together with rst is ignored.
- Width rule: the prescaler is $clog2(CLK_DIV) bits wide, and the index is 2 bits.

Decomposition:
- Shared package/header:
  - ANODE_OFF = 4'b1111.
  - Digit-index width = 2.
  - Default CLK_DIV.
- Sub-module: clk_prescaler (parameter CLK_DIV; ports clk, rst, tick). It is natural to separate because other display and debounce blocks reuse it.
- Leading-zero logic and the double buffer stay inline.

Test Plan:
- Reset hold: rst high for 3 cycles → an=1111, Hex=0, dp=0, frame_tick=0; the first cycle after release gives an=1110, Hex=0.
- Scan order: CLK_DIV=4, blank_lz=0, load value 16'h1234 with dp_in=4'b0100 → after the next wrap, per 4-cycle slot:
  - an=1110 with Hex=4;
  - an=1101 with Hex=3;
  - an=1011 with Hex=2 and dp=1;
  - an=0111 with Hex=1;
  - frame_tick pulses once every 16 cycles.
- Frame-boundary buffering: display 16'hAAAA, then load 16'h5555 mid-frame at digit 1 → digits 1..3 of the current frame still show A; the first 5 appears on digit 0 right after frame_tick.
- Coincident load and wrap: load 16'h0F0F in exactly the wrap_tick cycle → the next frame shows 0F0F; the pending flag is cleared.
- Leading-zero blanking: blank_lz=1 →
  - value 16'h0007 gives an=1111 on slots 1..3 and Hex=7 on slot 0;
  - value 16'h0000 displays only digit 0;
  - value 16'h0000 with dp_in=4'b0100 lights digits 0..2.
- Mid-scan reset: assert rst while index=2 with pending loaded → outputs go to reset values next cycle; after release, active=0, so digit 0 shows Hex=0 and the pending value never appears.
